trace_dump_unit: RTL and testbench
==================================

// Module: trace_dump_unit
// PURPOSE
//  Synthesizable in-system debug capture for the microprocessor.
//  Records (PC, IR, E, AC) for every retired instruction in a circular trace buffer.
//  On halt, streams the buffered trace and then a full data-memory dump over a valid/ready port.
//  Sits beside the core and taps its retire strobe, its architectural state and a spare data-bank read port.
// PARAMETERS
//  DW        16   accumulator / data-memory word width
//  AW        7    data-memory address width
//  MEM_WORDS 128  words dumped, addresses 0..MEM_WORDS-1 (MEM_WORDS <= 2**AW)
//  PCW       8    program-counter width
//  IRW       16   instruction-register width
//  TDEPTH    16   trace entries; power of 2, >= 2
//  TW        PCW+IRW+1+DW  output word width (derived; must not be overridden)
// PORTS
//  clk1       in   1     single system clock, rising edge
//  rst        in   1     asynchronous, active-high reset
//  retire     in   1     one instruction committed this cycle
//  pc_in      in   PCW   PC of the retiring instruction
//  ir_in      in   IRW   IR of the retiring instruction
//  e_in       in   1     E flag after the instruction
//  ac_in      in   DW    AC after the instruction
//  hlt        in   1     core halted; level, sampled each cycle
//  mem_rd     out  1     data-memory read strobe
//  mem_addr   out  AW    data-memory read address
//  mem_rdata  in   DW    read data, valid exactly 1 cycle after mem_rd
//  out_valid  out  1     out_data/out_tag valid
//  out_ready  in   1     sink accepts; a transfer occurs when valid & ready
//  out_data   out  TW    trace {pc,ir,e,ac}, or a memory word zero-extended
//  out_tag    out  2     00 trace, 01 memory, 11 end marker
//  overflow   out  1     sticky: at least one trace entry was overwritten
//  busy       out  1     dump in progress
//  done       out  1     dump complete; held until rst
// BEHAVIOUR
//  Reset: all outputs 0; FSM=CAPTURE; write ptr, count and overflow cleared; asserts immediately.
//  FSM states: CAPTURE -> DRAIN -> MREQ -> MWAIT -> MOUT -> (MREQ | ENDM) -> DONE.
//  CAPTURE
//   - retire=1: write entry at wptr; wptr+1 mod TDEPTH; count saturates at TDEPTH.
//   - retire with count==TDEPTH: overwrite the oldest entry and set overflow.
//   - hlt=1 sampled: go to DRAIN next cycle. A retire in the same cycle is captured first.
//  DRAIN
//   - busy=1. Emit entries oldest-first; oldest = (wptr-count) mod TDEPTH; tag 00.
//   - First out_valid appears the cycle after hlt is sampled.
//   - An empty buffer goes straight to MREQ.
//  Handshake
//   - out_valid=1 holds out_data/out_tag stable until accepted.
//   - Next word is presented no earlier than the cycle after acceptance.
//   - out_valid never drops without a transfer.
//  MREQ: mem_rd=1 for exactly 1 cycle, mem_addr=addr. addr starts at 0 on entry from DRAIN.
//  MWAIT: capture mem_rdata into the output register.
//  MOUT: out_valid=1, tag 01.
//   - On transfer: addr==MEM_WORDS-1 goes to ENDM; otherwise addr+1 and back to MREQ.
//   - mem_addr holds its last value while mem_rd=0.
//  ENDM: out_data = {TW-1 zeros, overflow}, tag 11; on transfer go to DONE.
//  DONE: busy=0, done=1, out_valid=0. Terminal until rst.
//  Ignored while busy or done: retire (not captured) and hlt deassertion (the dump completes).
//  Total transfers = count + MEM_WORDS + 1.
//  With out_ready held high, each memory word costs 3 cycles.
// TESTING
//  1. rst mid-dump (MOUT, addr=5) -> next cycle out_valid=0, busy=0, done=0, overflow=0.
//     Then a new retire+hlt produces a clean dump.
//  2. Retire 3 entries (pc 0,1,2), hlt, out_ready=1:
//     - 3 trace words in order (tag 00);
//     - 128 memory words at addr 0..127 with tag 01, data equal to the preloaded pattern mem[i]=i^16'hA5A5;
//     - end word with data 0, tag 11;
//     - done=1.
//  3. Retire 20 entries (pc 0..19) with TDEPTH=16 -> overflow=1; trace emits pc 4..19; end-marker data lsb=1.
//  4. Drop out_ready for 5 cycles mid-trace and mid-memory -> out_data/out_tag stable, no word lost or duplicated.
//  5. retire and hlt in the same cycle with an empty buffer -> exactly 1 trace word.
//     hlt with no retire ever -> first output is mem addr 0.
//  6. Retire pulses during the dump are not captured.
//     hlt dropped during the dump -> dump still completes.

Source files
------------

// File: rtl/trace_dump_unit_if.sv
// Dump stream and data-memory read port of the trace dump unit.
// The master side is the dump unit; the slave side is the sink and memory.
interface trace_dump_unit_if #(
    parameter int DW = 16,
    parameter int AW = 7,
    parameter int TW = 41
);
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [TW-1:0] out_data;
    logic [1:0]    out_tag;

    modport master (
        output mem_rd, mem_addr, out_valid, out_data, out_tag,
        input  mem_rdata, out_ready
    );

    modport slave (
        input  mem_rd, mem_addr, out_valid, out_data, out_tag,
        output mem_rdata, out_ready
    );
endinterface

// File: rtl/trace_dump_unit.sv
// Debug capture: circular trace of retired instructions, then on halt
// streams the trace, a full data-memory dump and an end marker.
module trace_dump_unit #(
    parameter int DW        = 16,
    parameter int AW        = 7,
    parameter int MEM_WORDS = 128,
    parameter int PCW       = 8,
    parameter int IRW       = 16,
    parameter int TDEPTH    = 16
) (
    input  logic           clk1,
    input  logic           rst,
    input  logic           retire,
    input  logic [PCW-1:0] pc_in,
    input  logic [IRW-1:0] ir_in,
    input  logic           e_in,
    input  logic [DW-1:0]  ac_in,
    input  logic           hlt,
    trace_dump_unit_if.master bus,
    output logic           overflow,
    output logic           busy,
    output logic           done
);
    localparam int TW  = PCW + IRW + 1 + DW;
    localparam int TPW = $clog2(TDEPTH);
    localparam int CW  = TPW + 1;

    localparam logic [2:0] S_CAP   = 3'd0;
    localparam logic [2:0] S_DRAIN = 3'd1;
    localparam logic [2:0] S_MREQ  = 3'd2;
    localparam logic [2:0] S_MWAIT = 3'd3;
    localparam logic [2:0] S_MOUT  = 3'd4;
    localparam logic [2:0] S_ENDM  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [CW-1:0] FULL = CW'(TDEPTH);
    localparam logic [AW-1:0] LAST = AW'(MEM_WORDS - 1);

    logic [2:0]     state;
    logic [TW-1:0]  tbuf [TDEPTH];
    logic [TPW-1:0] wptr;
    logic [TPW-1:0] rptr;
    logic [CW-1:0]  count;
    logic [CW-1:0]  left;
    logic [AW-1:0]  addr;
    logic           vld;
    logic [TW-1:0]  dat;
    logic [1:0]     tag;

    logic           cap_we;
    logic           xfer;
    logic [TW-1:0]  ret_word;
    logic [TPW-1:0] wptr_nx;
    logic [CW-1:0]  count_nx;
    logic [TPW-1:0] oldest;
    logic [TW-1:0]  oldest_word;

    assign ret_word = {pc_in, ir_in, e_in, ac_in};
    assign cap_we   = (state == S_CAP) && retire;
    assign xfer     = vld && bus.out_ready;

    // Pointer/count as they will be after this cycle's retire, so a
    // retire coinciding with hlt is already part of the drained trace.
    assign wptr_nx  = cap_we ? wptr + TPW'(1) : wptr;
    assign count_nx = (cap_we && count != FULL) ? count + CW'(1) : count;
    assign oldest   = wptr_nx - count_nx[TPW-1:0];
    // The oldest slot can be the one being written right now.
    assign oldest_word = (cap_we && oldest == wptr) ? ret_word
                                                    : tbuf[oldest];

    assign bus.mem_rd    = (state == S_MREQ);
    assign bus.mem_addr  = addr;
    assign bus.out_valid = vld;
    assign bus.out_data  = dat;
    assign bus.out_tag   = tag;

    assign busy = (state == S_DRAIN) || (state == S_MREQ) ||
                  (state == S_MWAIT) || (state == S_MOUT) ||
                  (state == S_ENDM);
    assign done = (state == S_DONE);

    // Trace storage write; contents need no reset.
    always_ff @(posedge clk1) begin
        if (cap_we) tbuf[wptr] <= ret_word;
    end

    // Capture bookkeeping and the dump sequencer.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state    <= S_CAP;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            left     <= '0;
            addr     <= '0;
            overflow <= 1'b0;
            vld      <= 1'b0;
            dat      <= '0;
            tag      <= 2'b00;
        end else begin
            unique case (state)
                S_CAP: begin
                    wptr  <= wptr_nx;
                    count <= count_nx;
                    if (cap_we && count == FULL) overflow <= 1'b1;
                    if (hlt) begin
                        addr <= '0;
                        if (count_nx == '0) begin
                            state <= S_MREQ;
                        end else begin
                            state <= S_DRAIN;
                            rptr  <= oldest;
                            left  <= count_nx;
                            vld   <= 1'b1;
                            dat   <= oldest_word;
                            tag   <= 2'b00;
                        end
                    end
                end
                S_DRAIN: begin
                    if (xfer) begin
                        if (left == CW'(1)) begin
                            vld   <= 1'b0;
                            addr  <= '0;
                            state <= S_MREQ;
                        end else begin
                            rptr <= rptr + TPW'(1);
                            left <= left - CW'(1);
                            dat  <= tbuf[rptr + TPW'(1)];
                        end
                    end
                end
                S_MREQ: begin
                    state <= S_MWAIT;
                end
                S_MWAIT: begin
                    vld   <= 1'b1;
                    dat   <= {{(TW-DW){1'b0}}, bus.mem_rdata};
                    tag   <= 2'b01;
                    state <= S_MOUT;
                end
                S_MOUT: begin
                    if (xfer) begin
                        if (addr == LAST) begin
                            dat   <= {{(TW-1){1'b0}}, overflow};
                            tag   <= 2'b11;
                            state <= S_ENDM;
                        end else begin
                            vld   <= 1'b0;
                            addr  <= addr + AW'(1);
                            state <= S_MREQ;
                        end
                    end
                end
                S_ENDM: begin
                    if (xfer) begin
                        vld   <= 1'b0;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                default: begin
                    state <= S_CAP;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_trace_dump_unit.sv
// Randomized bench for trace_dump_unit against a queue-based model
// of the expected dump stream.
module tb_trace_dump_unit;
    localparam int DW        = 16;
    localparam int AW        = 7;
    localparam int MEM_WORDS = 128;
    localparam int PCW       = 8;
    localparam int IRW       = 16;
    localparam int TDEPTH    = 16;
    localparam int TW        = PCW + IRW + 1 + DW;

    logic           clk1 = 1'b0;
    logic           rst;
    logic           retire;
    logic [PCW-1:0] pc_in;
    logic [IRW-1:0] ir_in;
    logic           e_in;
    logic [DW-1:0]  ac_in;
    logic           hlt;
    logic           overflow;
    logic           busy;
    logic           done;

    trace_dump_unit_if #(.DW(DW), .AW(AW), .TW(TW)) bus ();

    trace_dump_unit #(
        .DW(DW), .AW(AW), .MEM_WORDS(MEM_WORDS),
        .PCW(PCW), .IRW(IRW), .TDEPTH(TDEPTH)
    ) dut (
        .clk1(clk1), .rst(rst), .retire(retire),
        .pc_in(pc_in), .ir_in(ir_in), .e_in(e_in), .ac_in(ac_in),
        .hlt(hlt), .bus(bus),
        .overflow(overflow), .busy(busy), .done(done)
    );

    always #5 clk1 = ~clk1;

    // Data memory: read data valid one cycle after the strobe,
    // garbage otherwise so a mistimed capture shows up.
    logic [DW-1:0] mem [MEM_WORDS];
    always @(posedge clk1) begin
        if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
        else            bus.mem_rdata <= DW'($urandom);
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: last TDEPTH retired words, sticky overflow, expected stream.
    logic [TW-1:0] tr_q [$];
    logic          m_ovf;
    logic [TW+1:0] exp_q [$];
    int            exp_tr;
    int            exp_total;

    task automatic model_retire(input logic [TW-1:0] w);
        tr_q.push_back(w);
        if (tr_q.size() > TDEPTH) begin
            void'(tr_q.pop_front());
            m_ovf = 1'b1;
        end
    endtask

    task automatic set_fields(input logic [PCW-1:0] pc);
        pc_in = pc;
        ir_in = IRW'($urandom);
        e_in  = 1'($urandom);
        ac_in = DW'($urandom);
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        retire = 1'b0;
        hlt    = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk1);
        rst = 1'b0;
        tr_q.delete();
        m_ovf = 1'b0;
        @(negedge clk1);
    endtask

    task automatic cap(input logic [PCW-1:0] pc);
        retire = 1'b1;
        set_fields(pc);
        model_retire({pc_in, ir_in, e_in, ac_in});
        @(negedge clk1);
        retire = 1'b0;
    endtask

    task automatic start_dump(input bit with_ret, input logic [PCW-1:0] pc);
        retire = with_ret;
        if (with_ret) begin
            set_fields(pc);
            model_retire({pc_in, ir_in, e_in, ac_in});
        end
        hlt = 1'b1;
        exp_q.delete();
        foreach (tr_q[i]) exp_q.push_back({2'b00, tr_q[i]});
        for (int i = 0; i < MEM_WORDS; i++)
            exp_q.push_back({2'b01, TW'(mem[i])});
        exp_q.push_back({2'b11, {(TW-1){1'b0}}, m_ovf});
        exp_tr    = tr_q.size();
        exp_total = exp_q.size();
        @(negedge clk1);
        retire = 1'b0;
        chk("first_valid", 64'(bus.out_valid), 64'(exp_tr != 0));
        chk("busy_on", 64'(busy), 64'(1));
    endtask

    // mode 0: ready high; 1: random ready; 2: two 5-cycle stalls.
    task automatic run_dump(input int mode, input bit noise,
                            input int abort_at, output bit aborted);
        int xf = 0;
        int mi = 0;
        int stall = 0;
        bit s1d = 0;
        bit s2d = 0;
        bit pv = 0;
        bit px = 0;
        bit r;
        logic [TW+1:0] pw = '0;
        logic [TW+1:0] got;
        logic [TW+1:0] ew;
        int s1 = exp_tr / 2;
        int s2 = exp_tr + 40;
        aborted = 1'b0;
        for (int c = 0; c < 20000 && !done; c++) begin
            if (pv && !px)
                chk("hold", 64'({bus.out_valid, bus.out_tag, bus.out_data}),
                    64'({1'b1, pw}));
            if (bus.mem_rd) chk("mem_addr", 64'(bus.mem_addr), 64'(mi));
            if (abort_at >= 0 && xf == abort_at && bus.out_valid) begin
                aborted = 1'b1;
                return;
            end
            if (mode == 0) begin
                r = 1'b1;
            end else if (mode == 1) begin
                r = ($urandom_range(0, 2) != 0);
            end else begin
                if (!s1d && xf == s1) begin stall = 5; s1d = 1; end
                if (!s2d && xf == s2) begin stall = 5; s2d = 1; end
                r = (stall == 0);
                if (stall > 0) stall--;
            end
            bus.out_ready = r;
            if (noise) begin
                retire = 1'($urandom);
                set_fields(PCW'($urandom));
                hlt = 1'($urandom);
            end
            px = bus.out_valid && r;
            if (px) begin
                got = {bus.out_tag, bus.out_data};
                if (exp_q.size() == 0) begin
                    chk("extra_word", 64'(xf), 64'(exp_total - 1));
                end else begin
                    ew = exp_q.pop_front();
                    chk("word", 64'(got), 64'(ew));
                    if (ew[TW+1:TW] == 2'b01) mi++;
                end
                xf++;
            end
            pv = bus.out_valid;
            pw = {bus.out_tag, bus.out_data};
            @(negedge clk1);
        end
        retire = 1'b0;
        bus.out_ready = 1'b0;
        chk("done", 64'(done), 64'(1));
        chk("remaining", 64'(exp_q.size()), 64'(0));
        chk("busy_off", 64'(busy), 64'(0));
        chk("valid_off", 64'(bus.out_valid), 64'(0));
    endtask

    bit ab;
    int n;

    initial begin
        rst    = 1'b1;
        retire = 1'b0;
        hlt    = 1'b0;
        pc_in  = '0;
        ir_in  = '0;
        e_in   = 1'b0;
        ac_in  = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = DW'(i) ^ 16'hA5A5;
        m_ovf = 1'b0;
        repeat (2) @(negedge clk1);
        chk("rst_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_ovf", 64'(overflow), 64'(0));
        chk("rst_memrd", 64'(bus.mem_rd), 64'(0));
        rst = 1'b0;
        @(negedge clk1);

        // Three entries, ready held high.
        for (int i = 0; i < 3; i++) cap(PCW'(i));
        chk("ovf_3", 64'(overflow), 64'(0));
        start_dump(1'b0, '0);
        run_dump(0, 1'b0, -1, ab);

        // Twenty entries wrap the buffer.
        do_reset();
        for (int i = 0; i < 20; i++) cap(PCW'(i));
        chk("ovf_20", 64'(overflow), 64'(1));
        start_dump(1'b0, '0);
        chk("oldest_pc", 64'(bus.out_data[TW-1 -: PCW]), 64'(4));
        run_dump(0, 1'b0, -1, ab);

        // Ready stalls mid-trace and mid-memory.
        do_reset();
        for (int i = 0; i < 10; i++) cap(PCW'(i + 50));
        start_dump(1'b0, '0);
        run_dump(2, 1'b0, -1, ab);

        // Reset in MOUT at address 5.
        do_reset();
        for (int i = 0; i < 20; i++) cap(PCW'(i));
        start_dump(1'b0, '0);
        run_dump(0, 1'b0, exp_tr + 5, ab);
        chk("abort_hit", 64'(ab), 64'(1));
        chk("abort_word", 64'(bus.out_data), 64'(TW'(mem[5])));
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(bus.out_valid), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_ovf", 64'(overflow), 64'(0));
        @(negedge clk1);
        chk("arst_done", 64'(done), 64'(0));
        do_reset();
        start_dump(1'b1, 8'h3C);
        run_dump(0, 1'b0, -1, ab);

        // hlt with nothing ever retired.
        do_reset();
        start_dump(1'b0, '0);
        chk("empty_tag", 64'(bus.out_valid), 64'(0));
        run_dump(0, 1'b0, -1, ab);

        // Retire and hlt noise during the dump.
        do_reset();
        for (int i = 0; i < 5; i++) cap(PCW'(i + 100));
        start_dump(1'b0, '0);
        run_dump(1, 1'b1, -1, ab);

        // Random rounds.
        for (int k = 0; k < 4; k++) begin
            do_reset();
            n = $urandom_range(0, 35);
            for (int i = 0; i < n; i++) cap(PCW'($urandom));
            chk("ovf_rand", 64'(overflow), 64'(m_ovf));
            start_dump(1'($urandom), PCW'($urandom));
            run_dump(1, 1'($urandom), -1, ab);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
